// File: rtl/ulpi_config_seq_if.sv
// rtl/ulpi_config_seq_if.sv - ULPI register-access engine bus between config sequencer and engine
interface ulpi_config_seq_if;
  logic       DIR;
  logic       busy;
  logic [7:0] REG_DATA_OUT;
  logic       WD;
  logic       RD;
  logic [5:0] ADDR;
  logic [7:0] REG_DATA_IN;

  modport master (
    input  DIR, busy, REG_DATA_OUT,
    output WD, RD, ADDR, REG_DATA_IN
  );

  modport slave (
    output DIR, busy, REG_DATA_OUT,
    input  WD, RD, ADDR, REG_DATA_IN
  );
endinterface

// File: rtl/ulpi_config_seq.sv
// rtl/ulpi_config_seq.sv - ULPI PHY startup register write/verify sequencer
module ulpi_config_seq #(
  parameter logic [15:0] STARTUP_CYCLES = 16'd600,
  parameter logic [7:0]  TIMEOUT        = 8'd255,
  parameter int          RETRIES        = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  ulpi_config_seq_if.master       bus,
  output logic                    active,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              err_index
);

  localparam logic [7:0] RETRY_LIMIT = 8'(RETRIES);
  localparam logic [1:0] LAST_INDEX  = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_STARTUP,
    S_ISSUE_WR,
    S_WAIT_WR,
    S_ISSUE_RD,
    S_WAIT_RD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  // Register table: Function Control, OTG Control, Interface Control
  function automatic logic [5:0] tbl_addr(input logic [1:0] i);
    case (i)
      2'd0:    tbl_addr = 6'h04;
      2'd1:    tbl_addr = 6'h0A;
      default: tbl_addr = 6'h07;
    endcase
  endfunction

  function automatic logic [7:0] tbl_data(input logic [1:0] i);
    case (i)
      2'd0:    tbl_data = 8'h48;
      default: tbl_data = 8'h00;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  retry_q, retry_d;
  logic [15:0] dly_q, dly_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        seen_q, seen_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [5:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [1:0]  err_idx_q, err_idx_d;
  logic        wd, rd;

  // State and datapath registers; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      retry_q   <= '0;
      dly_q     <= '0;
      tmo_q     <= '0;
      seen_q    <= 1'b0;
      rdata_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      dly_q     <= dly_d;
      tmo_q     <= tmo_d;
      seen_q    <= seen_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_idx_q <= err_idx_d;
    end
  end

  // Next-state logic, one-cycle request strobes and per-access bookkeeping
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    dly_d     = dly_q;
    tmo_d     = tmo_q;
    seen_d    = seen_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_idx_d = err_idx_q;
    wd        = 1'b0;
    rd        = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d   = S_STARTUP;
          idx_d     = '0;
          retry_d   = '0;
          err_idx_d = '0;
          dly_d     = STARTUP_CYCLES;
        end
      end

      S_STARTUP: begin
        if (dly_q == '0) state_d = S_ISSUE_WR;
        else             dly_d   = dly_q - 16'd1;
      end

      S_ISSUE_WR: begin
        tmo_d = tmo_q - 8'd1;
        if (tmo_q <= 8'd1) begin
          state_d = S_ERROR;
        end else if (!bus.DIR && !bus.busy) begin
          wd      = 1'b1;
          seen_d  = 1'b0;
          state_d = S_WAIT_WR;
        end
      end

      S_WAIT_WR: begin
        tmo_d = tmo_q - 8'd1;
        if (tmo_q <= 8'd1)               state_d = S_ERROR;
        else if (seen_q && !bus.busy)    state_d = S_ISSUE_RD;
        else if (bus.busy)               seen_d  = 1'b1;
      end

      S_ISSUE_RD: begin
        tmo_d = tmo_q - 8'd1;
        if (tmo_q <= 8'd1) begin
          state_d = S_ERROR;
        end else if (!bus.DIR && !bus.busy) begin
          rd      = 1'b1;
          seen_d  = 1'b0;
          state_d = S_WAIT_RD;
        end
      end

      S_WAIT_RD: begin
        tmo_d = tmo_q - 8'd1;
        if (tmo_q <= 8'd1) begin
          state_d = S_ERROR;
        end else if (seen_q && !bus.busy) begin
          rdata_d = bus.REG_DATA_OUT;
          state_d = S_CHECK;
        end else if (bus.busy) begin
          seen_d = 1'b1;
        end
      end

      S_CHECK: begin
        if (rdata_q == tbl_data(idx_q)) begin
          if (idx_q == LAST_INDEX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            retry_d = '0;
            state_d = S_ISSUE_WR;
          end
        end else if (retry_q < RETRY_LIMIT) begin
          retry_d = retry_q + 8'd1;
          state_d = S_ISSUE_WR;
        end else begin
          state_d = S_ERROR;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Each new access gets a fresh timeout; the write also latches its table entry
    if (state_d == S_ISSUE_WR && state_q != S_ISSUE_WR) begin
      tmo_d   = TIMEOUT;
      addr_d  = tbl_addr(idx_d);
      wdata_d = tbl_data(idx_d);
    end
    if (state_d == S_ISSUE_RD && state_q != S_ISSUE_RD) begin
      tmo_d = TIMEOUT;
    end
    if (state_d == S_ERROR && state_q != S_ERROR) begin
      err_idx_d = idx_q;
    end
  end

  assign bus.WD          = wd;
  assign bus.RD          = rd;
  assign bus.ADDR        = addr_q;
  assign bus.REG_DATA_IN = wdata_q;
  assign active          = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
  assign done            = (state_q == S_DONE);
  assign error           = (state_q == S_ERROR);
  assign err_index       = err_idx_q;

endmodule

// File: tb/tb_ulpi_config_seq.sv
// tb/tb_ulpi_config_seq.sv - scoreboard bench for ulpi_config_seq with randomized engine model
module tb_ulpi_config_seq;

  localparam logic [15:0] SC = 16'd10;
  localparam logic [7:0]  TO = 8'd40;
  localparam int          RT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       active, done, error;
  logic [1:0] err_index;

  ulpi_config_seq_if bus();

  ulpi_config_seq #(.STARTUP_CYCLES(SC), .TIMEOUT(TO), .RETRIES(RT)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .active(active), .done(done), .error(error), .err_index(err_index)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_rd;
    logic [5:0] addr;
    logic [7:0] data;
  } acc_t;

  acc_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  logic [5:0] t_addr [3] = '{6'h04, 6'h0A, 6'h07};
  logic [7:0] t_data [3] = '{8'h48, 8'h00, 8'h00};

  // engine / PHY model configuration
  int         bad_cnt [3];
  logic [7:0] bad_val [3];
  int         rd_cnt  [3];
  bit         no_busy  = 0;
  bit         dir_rand = 0;
  int         dir_force = 0;
  logic [7:0] regfile [64];

  // expected outcome
  bit       exp_done, exp_err;
  int       exp_idx;

  // monitor statistics
  int n_wd_total = 0;
  int n_rd_total = 0;
  int last_wd_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, expv);
    end
  endtask

  task automatic chk_range(input string nm, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_miss++;
      $display("FAIL %s: got %0d, required %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // engine model: busy high for 4 cycles per access, read echoes the last write
  // unless the entry is configured to return a bad value for its first reads
  logic       s_wd, s_rd;
  logic [5:0] s_addr;
  logic [7:0] s_data;
  int         eng_cnt = 0;
  bit         pend_rd = 0;
  logic [7:0] rb_val  = 8'h00;
  int         dir_cnt = 0;

  initial begin
    bus.busy = 1'b0;
    bus.DIR = 1'b0;
    bus.REG_DATA_OUT = 8'h00;
    for (int i = 0; i < 64; i++) regfile[i] = 8'hA5;
    forever begin
      @(negedge clk);
      s_wd   = bus.WD;
      s_rd   = bus.RD;
      s_addr = bus.ADDR;
      s_data = bus.REG_DATA_IN;
      @(posedge clk);
      #1;
      if (!rst) begin
        bus.busy = 1'b0;
        bus.DIR  = 1'b0;
        eng_cnt  = 0;
        dir_cnt  = 0;
        continue;
      end
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          bus.busy = 1'b0;
          if (pend_rd) bus.REG_DATA_OUT = rb_val;
        end
      end else if ((s_wd || s_rd) && !no_busy) begin
        bus.busy = 1'b1;
        eng_cnt  = 4;
        pend_rd  = s_rd;
        if (s_wd) begin
          regfile[s_addr] = s_data;
        end else begin
          int k;
          k = -1;
          for (int i = 0; i < 3; i++) if (t_addr[i] == s_addr) k = i;
          rb_val = regfile[s_addr];
          if (k >= 0) begin
            if (rd_cnt[k] < bad_cnt[k]) rb_val = bad_val[k];
            rd_cnt[k]++;
          end
        end
      end
      if (dir_force > 0) begin
        bus.DIR = 1'b1;
        dir_force--;
      end else if (dir_cnt > 0) begin
        bus.DIR = 1'b1;
        dir_cnt--;
      end else if (dir_rand && !bus.DIR && $urandom_range(0, 7) == 0) begin
        bus.DIR = 1'b1;
        dir_cnt = $urandom_range(0, 2);
      end else begin
        bus.DIR = 1'b0;
      end
    end
  end

  // monitor: pops the scoreboard on every request strobe
  bit         hold_on = 0;
  bit         hold_seen = 0;
  logic [5:0] hold_addr;
  logic [7:0] hold_data;

  initial begin
    acc_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold_on = 0;
        continue;
      end
      if (bus.WD || bus.RD) begin
        chk("wd_rd_exclusive", 32'(bus.WD & bus.RD), 32'd0);
        chk("dir_low_at_pulse", 32'(bus.DIR), 32'd0);
        if (bus.WD) begin
          n_wd_total++;
          last_wd_cyc = cyc;
        end else begin
          n_rd_total++;
        end
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_pulse: got WD=%0b RD=%0b ADDR=0x%0h, required no pulse",
                   bus.WD, bus.RD, bus.ADDR);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind_rd", 32'(bus.RD), 32'(e.is_rd));
          chk("pulse_addr", 32'(bus.ADDR), 32'(e.addr));
          if (!e.is_rd) chk("pulse_wdata", 32'(bus.REG_DATA_IN), 32'(e.data));
        end
        hold_on   = 1;
        hold_seen = 0;
        hold_addr = bus.ADDR;
        hold_data = bus.REG_DATA_IN;
      end else if (hold_on) begin
        if (bus.busy) begin
          hold_seen = 1;
        end else if (hold_seen) begin
          chk("addr_stable", 32'(bus.ADDR), 32'(hold_addr));
          chk("wdata_stable", 32'(bus.REG_DATA_IN), 32'(hold_data));
          hold_on = 0;
        end
      end
    end
  end

  // reference model: per entry, up to 1+RT write/readback attempts
  task automatic push_model();
    acc_t a;
    logic [7:0] rb;
    bit ok;
    exp_done = 1;
    exp_err  = 0;
    exp_idx  = 0;
    for (int i = 0; i < 3; i++) begin
      ok = 0;
      for (int t = 0; t <= RT; t++) begin
        a.is_rd = 0; a.addr = t_addr[i]; a.data = t_data[i];
        exp_q.push_back(a);
        a.is_rd = 1;
        exp_q.push_back(a);
        rb = (t < bad_cnt[i]) ? bad_val[i] : t_data[i];
        if (rb == t_data[i]) begin
          ok = 1;
          break;
        end
      end
      if (!ok) begin
        exp_done = 0;
        exp_err  = 1;
        exp_idx  = i;
        break;
      end
    end
  endtask

  task automatic setup(input int b0, input int b1, input int b2,
                       input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2,
                       input bit nb, input bit dr);
    bad_cnt[0] = b0; bad_cnt[1] = b1; bad_cnt[2] = b2;
    bad_val[0] = v0; bad_val[1] = v1; bad_val[2] = v2;
    for (int i = 0; i < 3; i++) rd_cnt[i] = 0;
    no_busy  = nb;
    dir_rand = dr;
  endtask

  task automatic check_started();
    chk("start_active", 32'(active), 32'd1);
    chk("start_done_clr", 32'(done), 32'd0);
    chk("start_error_clr", 32'(error), 32'd0);
    chk("start_err_index_clr", 32'(err_index), 32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_started();
  endtask

  task automatic wait_end();
    int k;
    k = 0;
    while (!(done || error) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) begin
      n_vec++;
      n_miss++;
      $display("FAIL end_wait: got no done/error after %0d cycles, required one", k);
    end
  endtask

  task automatic check_end();
    chk("end_done", 32'(done), 32'(exp_done));
    chk("end_error", 32'(error), 32'(exp_err));
    chk("end_err_index", 32'(err_index), 32'(exp_idx));
    chk("end_active", 32'(active), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_wd(input int target);
    int k;
    k = 0;
    while (n_wd_total < target && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) begin
      n_vec++;
      n_miss++;
      $display("FAIL wd_wait: got %0d WD pulses, required %0d", n_wd_total, target);
    end
  endtask

  task automatic run(input bit mid_start);
    int snap;
    push_model();
    snap = n_wd_total;
    pulse_start();
    if (mid_start) begin
      wait_wd(snap + 1);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_end();
    check_end();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_WD"}, 32'(bus.WD), 32'd0);
    chk({tag, "_RD"}, 32'(bus.RD), 32'd0);
    chk({tag, "_ADDR"}, 32'(bus.ADDR), 32'd0);
    chk({tag, "_REG_DATA_IN"}, 32'(bus.REG_DATA_IN), 32'd0);
    chk({tag, "_active"}, 32'(active), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_err_index"}, 32'(err_index), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap, c0, e_cyc;
    acc_t a;
    rst   = 1'b0;
    start = 1'b0;
    setup(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // nominal sequence, with a start pulse during the run that must be ignored
    setup(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    run(1);

    // entry 1 reads 0xFF twice then matches
    setup(0, 2, 0, 8'h00, 8'hFF, 8'h00, 0, 0);
    run(0);

    // entry 0 always reads 0x00: retries exhausted
    setup(3, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    run(0);

    // engine never goes busy: timeout on the first write
    setup(0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0);
    a.is_rd = 0; a.addr = 6'h04; a.data = 8'h48;
    exp_q.push_back(a);
    exp_done = 0; exp_err = 1; exp_idx = 0;
    snap = n_rd_total;
    pulse_start();
    wait_end();
    e_cyc = cyc;
    chk_range("timeout_cycles", e_cyc - last_wd_cyc, int'(TO) - 1, int'(TO) + 1);
    check_end();
    chk("timeout_no_rd", 32'(n_rd_total - snap), 32'd0);
    no_busy = 0;

    // DIR held high across ISSUE_WR entry
    setup(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    push_model();
    snap = n_wd_total;
    @(negedge clk);
    start = 1'b1;
    dir_force = int'(SC) + 22;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    check_started();
    wait_wd(snap + 1);
    chk_range("dir_wd_delay", last_wd_cyc - c0, int'(SC) + 20, 1000);
    wait_end();
    check_end();

    // reset one cycle after the second write
    setup(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    push_model();
    snap = n_wd_total;
    pulse_start();
    wait_wd(snap + 2);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_all_zero("midreset");
    rst = 1'b1;
    repeat (15) @(negedge clk);
    chk("post_reset_idle", 32'(active), 32'd0);
    setup(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    run(0);

    // randomized read-back corruption, DIR activity and stray starts
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 3; i++) begin
        bad_cnt[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
        bad_val[i] = t_data[i] ^ 8'($urandom_range(1, 255));
        rd_cnt[i]  = 0;
      end
      no_busy  = 0;
      dir_rand = 1;
      run(bit'($urandom_range(0, 1)));
    end
    dir_rand = 0;

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ulpi_config_seq.md
ULPI_CONFIG_SEQ -- requirements
Module: ulpi_config_seq

Interface
REQ-001 SHALL have parameter STARTUP_CYCLES, default 16'd600, PHY settle delay in clk cycles after start.
REQ-002 SHALL have parameter TIMEOUT, default 8'd255, max clk cycles per register access.
REQ-003 SHALL have parameter RETRIES, default 2, extra write+readback attempts per entry after a mismatch.
REQ-004 SHALL have one clock; reset is synchronous and active-low; port names: clk, rst.
REQ-005 Ports:
- clk  in  1  60 MHz PHY clock
- rst  in  1  synchronous active-low reset
- start  in  1  pulse: begin config sequence
- DIR  in  1  ULPI DIR, PHY owns bus when 1
- busy  in  1  ULPI register-access engine busy
- REG_DATA_OUT  in  8  read-back data from engine
- WD  out  1  one-cycle register-write request
- RD  out  1  one-cycle register-read request
- ADDR  out  6  register address
- REG_DATA_IN  out  8  write data
- active  out  1  sequence in progress
- done  out  1  all entries written and verified
- error  out  1  sequence aborted
- err_index  out  2  table entry that failed

Function
REQ-006 SHALL contain a fixed 3-entry table, index 0..2: (0x04, 0x48) Function Control, non-driving, HS, SuspendM=1; (0x0A, 0x00) OTG Control, pulldowns off; (0x07, 0x00) Interface Control.
REQ-007 SHALL implement states IDLE, STARTUP, ISSUE_WR, WAIT_WR, ISSUE_RD, WAIT_RD, CHECK, DONE, ERROR.
REQ-008 IDLE/DONE/ERROR + start=1 -> STARTUP; index, retry count, done, error cleared; delay counter loaded with STARTUP_CYCLES.
REQ-009 STARTUP: counter decrements each cycle; at 0 -> ISSUE_WR.
REQ-010 ISSUE_WR: if DIR=0 and busy=0, assert WD for exactly one cycle with ADDR/REG_DATA_IN = table[index] -> WAIT_WR; otherwise stay, WD=0.
REQ-011 WAIT_WR: first wait for busy=1, then for busy=0; on busy falling -> ISSUE_RD.
REQ-012 ISSUE_RD/WAIT_RD: same rules as REQ-010/011 using RD; on busy falling, capture REG_DATA_OUT -> CHECK.
REQ-013 CHECK: on match, index 2 -> DONE, else index+1 -> ISSUE_WR with retry count cleared; on mismatch, retry count < RETRIES -> increment, ISSUE_WR on the same index, else -> ERROR.
REQ-014 Timeout counter SHALL reload with TIMEOUT on entry to ISSUE_WR/ISSUE_RD, decrement every cycle in ISSUE_*/WAIT_*; reaching 0 -> ERROR.
REQ-015 ADDR and REG_DATA_IN SHALL remain stable from the WD/RD cycle until leaving the matching WAIT state.
REQ-016 WD and RD SHALL never be asserted together; neither SHALL assert while DIR=1.
REQ-017 active=1 in STARTUP..CHECK; done=1 only in DONE; error=1 only in ERROR; flags hold until the next start or reset.
REQ-018 err_index SHALL latch index on entry to ERROR; otherwise 0 after start.
REQ-019 start SHALL be ignored while active=1.
REQ-020 DIR rising during WAIT_*: SHALL keep waiting; the timeout still applies.

Reset
REQ-021 rst=0 at a clk edge SHALL force IDLE; WD=RD=0, ADDR=0, REG_DATA_IN=0, active=done=error=0, err_index=0; all counters cleared, effective next cycle.
REQ-022 Reset during any state, including mid-access, SHALL abort with no further WD/RD pulses.

Verification
REQ-023 start, busy model 4 cycles per access, read-back echoes write data -> exactly 3 WD and 3 RD pulses in order 0x04, 0x0A, 0x07; done=1; error=0.
REQ-024 Read-back of entry 1 returns 0xFF twice, then 0x00 -> entry 1 written 3 times total; done=1.
REQ-025 Read-back of entry 0 always 0x00 -> 3 write attempts; error=1, err_index=0, done=0.
REQ-026 busy never rises after first WD -> error=1 after TIMEOUT cycles; err_index=0; no RD issued.
REQ-027 DIR=1 held for 20 cycles when ISSUE_WR is entered -> WD delayed until DIR=0; no pulse while DIR=1; sequence completes.
REQ-028 rst=0 one cycle after second WD -> next cycle all outputs 0, state IDLE; new start reruns from index 0.
